// File: rtl/imem_pkg.sv
// Shared state encoding, parameter defaults and address-fault helper for the
// instruction-RAM port controller.
package imem_pkg;

   localparam int          ADDR_W_DEF    = 8;
   localparam logic [31:0] NOP_INSTR_DEF = 32'h0000_0013;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_FETCH,
      ST_LOAD,
      ST_DONE
   } state_t;

   // A fetch faults when the word is misaligned or lies beyond the RAM depth.
   function automatic logic fetch_fault(input logic [31:0] addr, input int aw);
      return (addr[1:0] != 2'b00) || ((addr >> aw) != 32'd0);
   endfunction

endpackage

// File: rtl/imem_word_asm.sv
// Walks four byte addresses from a latched base and assembles {b3,b2,b1,b0}.
// Latency: 5 edges from start to fetch_valid (1 on fault); start only when idle, no backpressure.
module imem_word_asm
   import imem_pkg::*;
#(
   parameter int          ADDR_W    = ADDR_W_DEF,
   parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              fault,
   input  logic [ADDR_W-1:0] base,
   input  logic [7:0]        mem_rdata,
   output logic [ADDR_W-1:0] rd_addr,
   output logic              done,
   output logic              fetch_valid,
   output logic [31:0]       fetch_instr,
   output logic              fetch_err
);

   logic [ADDR_W-1:0] base_q, base_d;
   logic [1:0]        cnt_q, cnt_d;
   logic [1:0]        lane_q, lane_d;
   logic              issue_q, issue_d;
   logic              cap_q, cap_d;
   logic [23:0]       sh_q, sh_d;
   logic [31:0]       instr_q, instr_d;
   logic              vld_q, vld_d;
   logic              err_q, err_d;

   assign rd_addr     = base_q + ADDR_W'(cnt_q);
   assign done        = cap_q && (lane_q == 2'd3);
   assign fetch_valid = vld_q;
   assign fetch_instr = instr_q;
   assign fetch_err   = err_q;

   always_comb begin
      base_d  = base_q;
      cnt_d   = cnt_q;
      issue_d = issue_q;
      sh_d    = sh_q;
      instr_d = instr_q;
      vld_d   = 1'b0;
      err_d   = 1'b0;
      // Read data for the address issued last cycle arrives this cycle.
      cap_d   = issue_q;
      lane_d  = cnt_q;

      if (issue_q) begin
         cnt_d = cnt_q + 2'd1;
         if (cnt_q == 2'd3) begin
            issue_d = 1'b0;
         end
      end

      if (cap_q) begin
         sh_d = {mem_rdata, sh_q[23:8]};
         if (lane_q == 2'd3) begin
            instr_d = {mem_rdata, sh_q};
            vld_d   = 1'b1;
         end
      end

      if (start) begin
         base_d  = base;
         cnt_d   = 2'd0;
         issue_d = !fault;
         if (fault) begin
            instr_d = NOP_INSTR;
            vld_d   = 1'b1;
            err_d   = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         base_q  <= '0;
         cnt_q   <= '0;
         lane_q  <= '0;
         issue_q <= 1'b0;
         cap_q   <= 1'b0;
         sh_q    <= '0;
         instr_q <= '0;
         vld_q   <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         base_q  <= base_d;
         cnt_q   <= cnt_d;
         lane_q  <= lane_d;
         issue_q <= issue_d;
         cap_q   <= cap_d;
         sh_q    <= sh_d;
         instr_q <= instr_d;
         vld_q   <= vld_d;
         err_q   <= err_d;
      end
   end

endmodule

// File: rtl/imem_port_ctrl.sv
// Arbitrates the byte-wide instruction RAM between core word fetches and a program loader.
// Latency: fetch 5 edges (fault 1), load 1 byte/cycle; fetch waits while core_hold, loader sees ld_ready.
module imem_port_ctrl
   import imem_pkg::*;
#(
   parameter int          ADDR_W    = ADDR_W_DEF,
   parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              fetch_req,
   input  logic [31:0]       fetch_addr,
   output logic              fetch_valid,
   output logic [31:0]       fetch_instr,
   output logic              fetch_err,
   input  logic              ld_start,
   input  logic              ld_valid,
   input  logic [7:0]        ld_data,
   input  logic              ld_last,
   output logic              ld_ready,
   output logic              ld_overflow,
   output logic              core_hold,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_we,
   output logic [7:0]        mem_wdata,
   input  logic [7:0]        mem_rdata
);

   state_t            state_q, state_d;
   logic [ADDR_W:0]   wcnt_q, wcnt_d;
   logic              ovf_q, ovf_d;
   logic              pend_q, pend_d;
   logic              asm_start;
   logic              asm_fault;
   logic              asm_done;
   logic [ADDR_W-1:0] asm_addr;
   logic              wr_full;

   // Top bit of the write counter marks that every RAM byte has been written.
   assign wr_full     = wcnt_q[ADDR_W];
   assign asm_fault   = fetch_fault(fetch_addr, ADDR_W);
   assign ld_overflow = ovf_q;

   imem_word_asm #(
      .ADDR_W    (ADDR_W),
      .NOP_INSTR (NOP_INSTR)
   ) u_word_asm (
      .clk         (clk),
      .rst         (rst),
      .start       (asm_start),
      .fault       (asm_fault),
      .base        (fetch_addr[ADDR_W-1:0]),
      .mem_rdata   (mem_rdata),
      .rd_addr     (asm_addr),
      .done        (asm_done),
      .fetch_valid (fetch_valid),
      .fetch_instr (fetch_instr),
      .fetch_err   (fetch_err)
   );

   always_comb begin
      state_d   = state_q;
      wcnt_d    = wcnt_q;
      ovf_d     = ovf_q;
      pend_d    = pend_q;
      asm_start = 1'b0;
      core_hold = 1'b0;
      ld_ready  = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;

      unique case (state_q)
         ST_IDLE: begin
            if (ld_start || pend_q) begin
               state_d = ST_LOAD;
               wcnt_d  = '0;
               ovf_d   = 1'b0;
               pend_d  = 1'b0;
            end else if (fetch_req) begin
               // A faulting fetch is answered by the assembler without leaving IDLE.
               asm_start = 1'b1;
               if (!asm_fault) begin
                  state_d = ST_FETCH;
               end
            end
         end

         ST_FETCH: begin
            mem_addr = asm_addr;
            if (ld_start) begin
               pend_d = 1'b1;
            end
            if (asm_done) begin
               state_d = ST_IDLE;
            end
         end

         ST_LOAD: begin
            core_hold = 1'b1;
            ld_ready  = 1'b1;
            mem_addr  = wcnt_q[ADDR_W-1:0];
            if (ld_valid) begin
               if (!wr_full) begin
                  mem_we    = 1'b1;
                  mem_wdata = ld_data;
                  wcnt_d    = wcnt_q + 1'b1;
               end else if (!ld_last) begin
                  ovf_d = 1'b1;
               end
               if (ld_last) begin
                  state_d = ST_DONE;
               end
            end
         end

         ST_DONE: begin
            core_hold = 1'b1;
            state_d   = ST_IDLE;
         end

         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         wcnt_q  <= '0;
         ovf_q   <= 1'b0;
         pend_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         wcnt_q  <= wcnt_d;
         ovf_q   <= ovf_d;
         pend_q  <= pend_d;
      end
   end

endmodule

// File: doc/imem_port_ctrl.md
# imem_port_ctrl

Sequencer and arbiter for the single-port, byte-wide instruction RAM. It lets the core fetch 32-bit little-endian words over the 8-bit port, one byte per cycle. It also lets a byte-stream program loader fill the RAM while the core is held. The block sits between the core fetch stage, the loader (UART/debug byte source) and the RAM macro.

## Interface
- ADDR_W, 8, RAM address width; depth is 2**ADDR_W bytes
- NOP_INSTR, 32'h00000013, word returned on a faulting fetch
---
- clk  in  1  sole clock, rising edge
- rst  in  1  asynchronous, active-high reset
- fetch_req  in  1  core requests the word at fetch_addr; held until fetch_valid
- fetch_addr  in  32  byte address of the word
- fetch_valid  out  1  one-cycle pulse; fetch_instr is valid this cycle
- fetch_instr  out  32  assembled word, {b3,b2,b1,b0}
- fetch_err  out  1  qualifies fetch_valid: misaligned or out-of-range address
- ld_start  in  1  one-cycle pulse that begins a program load at byte 0
- ld_valid  in  1  loader byte available
- ld_data  in  8  loader byte
- ld_last  in  1  marks the final byte, qualified by ld_valid
- ld_ready  out  1  byte accepted when ld_valid && ld_ready
- ld_overflow  out  1  sticky: more than 2**ADDR_W bytes were offered; cleared by ld_start or rst
- core_hold  out  1  core must stall/hold in reset while high
- mem_addr  out  ADDR_W  RAM address
- mem_we  out  1  RAM byte write enable
- mem_wdata  out  8  RAM write data
- mem_rdata  in  8  RAM read data; synchronous, valid the cycle after mem_addr is presented

## Operation
- States: IDLE, FETCH, LOAD, DONE.
- Reset values: IDLE, core_hold=0, all other outputs 0, mem_addr=0.
- IDLE, ld_start=1 → LOAD. ld_start takes priority over a simultaneous fetch_req, which is ignored.
- IDLE, fetch_req=1, core_hold=0 → FETCH.
  - The address is latched.
  - If fetch_addr[1:0]!=0 or fetch_addr[31:ADDR_W]!=0, there is no RAM access. fetch_valid=1, fetch_err=1 and fetch_instr=NOP_INSTR are driven on the next cycle; the state returns to IDLE.
- FETCH:
  - A 2-bit byte counter drives mem_addr = base+k for k=0..3, one per cycle, with wrap modulo 2**ADDR_W.
  - Returning mem_rdata is shifted into byte lane k.
  - After lane 3 is captured, fetch_valid pulses with fetch_err=0, then the state returns to IDLE.
  - fetch_instr holds its last value between pulses.
- ld_start during FETCH is latched as pending. The fetch completes, then the state goes to LOAD from IDLE on the following cycle.
- ld_start during LOAD or DONE is ignored.
- LOAD:
  - core_hold=1 and ld_ready=1.
  - Each accepted byte gives mem_we=1, mem_addr=wptr, mem_wdata=ld_data in the same cycle; wptr then increments.
  - wptr reset: it is cleared on LOAD entry.
  - Once 2**ADDR_W bytes are written, further accepted non-last bytes set ld_overflow and are dropped (mem_we=0). ld_ready stays high.
  - An accepted ld_last byte is written (if room remains) → DONE.
- DONE: one cycle with core_hold=1 and ld_ready=0 → IDLE. core_hold falls on entry to IDLE.
- fetch_req is not serviced while core_hold=1.
- rst mid-fetch or mid-load:
  - The state goes to IDLE immediately and the partial word is discarded.
  - core_hold drops and ld_overflow clears.
  - RAM contents are whatever was already written.

## Timing
- Aligned fetch accepted at edge E0:
  - mem_addr=base+k during the cycle after edge E(k).
  - Lane k is captured at edge E(k+2).
  - fetch_valid is high for the cycle after E5. Fetch latency is 5 edges.
- Next fetch_req is accepted at the edge ending the fetch_valid cycle at the earliest, so throughput is one word per 6 cycles.
- Faulting fetch: fetch_valid is high for the cycle after the accepting edge.
- Load: one byte per cycle sustained. ld_ready is combinational from state only, with no dependence on ld_valid.
- ld_start at edge S: ld_ready=1 from the cycle after S.

## Structure
- Package imem_pkg holds the state enum, NOP_INSTR default and ADDR_W default.
- One sub-module, imem_word_asm: byte counter, lane shift register and fetch_valid generation. The top holds the FSM, load pointer and RAM port muxing.

## Test plan
- Load 0x93,0x00,0xA0,0x02 (last on 4th), then fetch addr 0:
  - Expect 4 writes to addrs 0-3, core_hold falling 2 cycles after the last byte.
  - Expect fetch_instr=0x02A00093 with fetch_valid 5 edges after acceptance.
- fetch_addr=0x2 → fetch_err=1, fetch_instr=0x00000013 next cycle, no mem access. fetch_addr=0x100 → same result.
- Fetch at 0xFC: addresses 0xFC..0xFF in order. Also force base 0xFD in a unit test of imem_word_asm to check wrap to 0x00.
- Offer 257 bytes without ld_last, then a last byte:
  - 256 writes occur and ld_overflow=1 stays set.
  - core_hold falls; the next ld_start clears ld_overflow.
- ld_start asserted mid-fetch → the fetch completes with correct data, then LOAD begins. Simultaneous ld_start+fetch_req in IDLE → LOAD and no fetch_valid.
- Assert rst during LOAD after 2 bytes → all outputs return to reset values asynchronously. A subsequent fetch of 0 returns the two written bytes in lanes 0-1.
